tt_neuron: RTL and testbench

TT_NEURON -- requirements
Module: tt_neuron

---
 rtl/tt_neuron.sv | 75 +++++++
 tb/tb_tt_neuron.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tt_neuron.sv
// tt_neuron: leaky integrate-and-fire neuron with runtime-loaded synapse weights
module tt_neuron (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] r_w0, r_w1, r_thr, r_u;
  logic [2:0] r_shift;
  logic [3:0] r_refp, r_cnt;
  logic r_spike;
  logic [15:0] w_wts;
  logic signed [9:0] w_sum, w_next;
  logic [7:0] w_leak, w_sat;
  logic w_fire, w_unused;
  assign w_wts = {r_w1, r_w0};
  assign w_unused = &{1'b0, uio_in[2:0]};
  // signed sum of the weights of every active synapse (11 encodes -1)
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++)
      if (ui_in[i]) w_sum = w_sum + ((w_wts[2*i+:2] == 2'b11) ? -10'sd1 : $signed({8'd0, w_wts[2*i+:2]}));
  end
  // leak, integrate, clamp to [0,255] and compare against threshold
  always_comb begin
    w_leak = (r_shift == 3'd0) ? r_u : r_u - (r_u >> r_shift);
    w_next = $signed({2'b00, w_leak}) + w_sum;
    w_sat = w_next[9] ? 8'd0 : (w_next[8] ? 8'hFF : w_next[7:0]);
    w_fire = w_sat >= r_thr;
  end
  // configuration register writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w0 <= 8'h55;
      r_w1 <= 8'h55;
      r_thr <= 8'h10;
      r_shift <= 3'd0;
      r_refp <= 4'd2;
    end else if (ena && uio_in[7]) begin
      if (uio_in[6:4] == 3'd0) r_w0 <= ui_in;
      if (uio_in[6:4] == 3'd1) r_w1 <= ui_in;
      if (uio_in[6:4] == 3'd2) r_thr <= ui_in;
      if (uio_in[6:4] == 3'd3) r_shift <= ui_in[2:0];
      if (uio_in[6:4] == 3'd4) r_refp <= ui_in[3:0];
    end
  end
  // membrane potential, refractory countdown and registered spike
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u <= '0;
      r_cnt <= '0;
      r_spike <= 1'b0;
    end else if (!ena || uio_in[7]) begin
      r_spike <= 1'b0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
      r_u <= '0;
      r_spike <= 1'b0;
    end else if (w_fire) begin
      r_spike <= 1'b1;
      r_u <= '0;
      r_cnt <= r_refp;
    end else begin
      r_spike <= 1'b0;
      r_u <= w_sat;
    end
  end
  assign uo_out = uio_in[3] ? r_u : {r_u[7:2], r_cnt != 4'd0, r_spike};
  assign uio_out = '0;
  assign uio_oe = '0;
endmodule

// File: tb/tb_tt_neuron.sv
// tb_tt_neuron: scoreboard bench for tt_neuron against an integer reference model
module tb_tt_neuron;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  string name_q[$];
  int mu, mcnt, mspk, mthr, mshift, mref;
  int mw[8];
  int wtab[4] = '{0, 1, 2, -1};

  tt_neuron dut (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
                 .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mu = 0; mcnt = 0; mspk = 0; mthr = 16; mshift = 0; mref = 2;
    foreach (mw[i]) mw[i] = 1;
  endtask

  function automatic logic [7:0] model_view(logic dbg);
    logic [7:0] u8;
    u8 = mu[7:0];
    return dbg ? u8 : {u8[7:2], mcnt != 0, mspk[0]};
  endfunction

  task automatic model_step(logic e, logic [7:0] ui, logic [7:0] ctl);
    int sum, lk, nx;
    if (!e) mspk = 0;
    else if (ctl[7]) begin
      mspk = 0;
      case (ctl[6:4])
        3'd0: for (int i = 0; i < 4; i++) mw[i] = int'(ui[2*i+:2]);
        3'd1: for (int i = 0; i < 4; i++) mw[4+i] = int'(ui[2*i+:2]);
        3'd2: mthr = int'(ui);
        3'd3: mshift = int'(ui[2:0]);
        3'd4: mref = int'(ui[3:0]);
        default: ;
      endcase
    end else if (mcnt > 0) begin
      mcnt--; mu = 0; mspk = 0;
    end else begin
      sum = 0;
      for (int i = 0; i < 8; i++) if (ui[i]) sum += wtab[mw[i]];
      lk = (mshift == 0) ? mu : mu - (mu >> mshift);
      nx = lk + sum;
      if (nx < 0) nx = 0;
      if (nx > 255) nx = 255;
      if (nx >= mthr) begin mspk = 1; mu = 0; mcnt = mref; end
      else begin mspk = 0; mu = nx; end
    end
  endtask

  task automatic step(logic e, logic [7:0] ui, logic [7:0] ctl, string nm);
    @(negedge clk);
    ena = e; ui_in = ui; uio_in = ctl;
    model_step(e, ui, ctl);
    exp_q.push_back(model_view(ctl[3]));
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; ui_in = '0; uio_in = '0;
    model_reset();
    #1 chk("reset_view", uo_out, 8'h00);
    uio_in = 8'h08;
    #1 chk("reset_debug", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      chk(name_q.pop_front(), uo_out, exp_q.pop_front());
      chk("uio_zero", uio_out | uio_oe, 8'h00);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq029[4];
    logic [7:0] ctl;
    seq029 = '{8'd8, 8'd12, 8'd14, 8'd15};
    model_reset();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 8'h01, 8'h08, "ramp");
      #1 chk("ramp_const", uo_out, 8'(k));
    end
    step(1'b1, 8'h01, 8'h00, "spike16");
    #1 chk("spike16_const", uo_out, 8'h03);
    step(1'b1, 8'h01, 8'h00, "refr1");
    #1 chk("refr1_const", uo_out, 8'h02);
    step(1'b1, 8'h01, 8'h00, "refr2");
    #1 chk("refr2_const", uo_out, 8'h00);
    step(1'b1, 8'h01, 8'h08, "resume");
    #1 chk("resume_const", uo_out, 8'h01);

    do_reset();
    step(1'b1, 8'h01, 8'hB0, "cfg_shift");
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'hFF, 8'h08, "leak_ramp");
      #1 chk("leak_const", uo_out, seq029[k]);
    end
    step(1'b1, 8'hFF, 8'h00, "leak_spike");
    #1 chk("leak_spike_const", uo_out, 8'h03);

    do_reset();
    step(1'b1, 8'hFF, 8'h80, "cfg_w0");
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h0F, 8'h08, "neg_clamp");
      #1 chk("clamp_const", uo_out, 8'h00);
    end
    step(1'b1, 8'h0F, 8'h00, "neg_nospike");
    #1 chk("nospike_const", uo_out, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 8'hF0, 8'h08, "pos4");
      #1 chk("pos4_const", uo_out, 8'(4 * k));
    end

    do_reset();
    step(1'b1, 8'hFF, 8'hA0, "cfg_thr");
    step(1'b1, 8'hAA, 8'h90, "cfg_w1");
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 8'hF0, 8'h08, "pos8");
      #1 chk("pos8_const", uo_out, 8'(8 * k));
    end
    step(1'b0, 8'hF0, 8'h08, "ena_hold");
    #1 chk("ena_hold_const", uo_out, 8'd24);
    step(1'b0, 8'hF0, 8'h00, "ena_hold_view");
    #1 chk("ena_view_const", uo_out, 8'h18);
    for (int k = 4; k <= 31; k++) step(1'b1, 8'hF0, 8'h08, "pos8_long");
    #1 chk("pos8_248_const", uo_out, 8'd248);
    step(1'b1, 8'hF0, 8'h00, "sat_spike");
    #1 chk("sat_spike_const", uo_out, 8'h03);

    do_reset();
    step(1'b1, 8'h02, 8'hA0, "cfg_thr2");
    step(1'b1, 8'h0F, 8'hC0, "cfg_refp");
    step(1'b1, 8'hFF, 8'h00, "fire");
    #1 chk("fire_const", uo_out, 8'h03);
    step(1'b1, 8'hFF, 8'h00, "refr_mid");
    #1 chk("refr_mid_const", uo_out, 8'h02);
    #2 rst_n = 1'b0;
    ena = 1'b0;
    model_reset();
    #1 chk("async_rst_view", uo_out, 8'h00);
    uio_in = 8'h08;
    #1 chk("async_rst_debug", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'hFF, 8'h08, "post_rst");
    #1 chk("post_rst_const", uo_out, 8'd8);

    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      ctl = {$urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom)};
      step($urandom_range(0, 9) != 0, 8'($urandom), ctl, "random");
    end
    @(posedge clk);
    #2 chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
